fetch_queue: RTL and testbench

Parametrised instruction-fetch front end with a request/response memory handshake and a DEPTH-entry instruction queue toward decode. It issues sequential PCs with static not-taken prediction (pre_pc = pc + 4) and buffers returned instructions. On a redirect it flushes the queue and discards any in-flight response. It replaces the combinational single-instruction fetch stage between PC select and decode.

---
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: one outstanding memory request,
// DEPTH-entry queue toward decode, static not-taken prediction.
module fetch_queue #(
   parameter int XLEN = 64,
   parameter int ILEN = 32,
   parameter int DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       imem_req_valid,
   input  logic                       imem_req_ready,
   output logic [XLEN-1:0]            imem_req_addr,
   input  logic                       imem_resp_valid,
   input  logic [ILEN-1:0]            imem_resp_instr,
   input  logic                       redirect_valid,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic                       fetch_o_valid,
   input  logic                       fetch_i_ready,
   output logic [XLEN-1:0]            fetch_o_pc,
   output logic [ILEN-1:0]            fetch_o_instr,
   output logic [XLEN-1:0]            fetch_o_pre_pc,
   output logic [$clog2(DEPTH):0]     fetch_o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] fly_pc;
   logic            busy;
   logic            drop;
   logic [AW-1:0]   head;
   logic [AW-1:0]   tail;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] q_pc    [DEPTH];
   logic [ILEN-1:0] q_instr [DEPTH];

   logic [CW:0] occ;
   logic        accept;
   logic        resp;
   logic        enq;
   logic        deq;

   // Credit check counts the in-flight request so the queue cannot overflow.
   assign occ = {1'b0, count} + (CW+1)'(busy);
   assign imem_req_valid = rst_n && !busy && !redirect_valid
                           && (occ < (CW+1)'(DEPTH));
   assign imem_req_addr = pc;

   assign accept = imem_req_valid && imem_req_ready;
   assign resp   = imem_resp_valid && busy;
   assign enq    = resp && !drop && !redirect_valid;
   assign deq    = fetch_o_valid && fetch_i_ready && !redirect_valid;

   assign fetch_o_valid  = (count != '0);
   assign fetch_o_pc     = q_pc[head];
   assign fetch_o_instr  = q_instr[head];
   assign fetch_o_pre_pc = q_pc[head] + XLEN'(4);
   assign fetch_o_count  = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= RESET_PC;
         fly_pc <= '0;
         busy   <= 1'b0;
         drop   <= 1'b0;
         head   <= '0;
         tail   <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         pc    <= redirect_pc;
         count <= '0;
         head  <= tail;
         if (resp) begin
            busy <= 1'b0;
            drop <= 1'b0;
         end else if (busy) begin
            drop <= 1'b1;
         end
      end else begin
         if (accept) begin
            fly_pc <= pc;
            pc     <= pc + XLEN'(4);
            busy   <= 1'b1;
         end
         if (resp) begin
            busy <= 1'b0;
            drop <= 1'b0;
         end
         if (enq) tail <= tail + AW'(1);
         if (deq) head <= head + AW'(1);
         if (enq && !deq) count <= count + CW'(1);
         else if (deq && !enq) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         q_pc[tail]    <= fly_pc;
         q_instr[tail] <= imem_resp_instr;
      end
   end

   a_resp_when_busy: assert property (
      @(posedge clk) disable iff (!rst_n) imem_resp_valid |-> busy
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus
// a mid-transaction reset sequence.
module tb_fetch_queue;

   localparam logic [63:0] B = 64'h8000_0000;
   localparam logic [63:0] WR = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic [63:0] req_addr;
   logic        resp_valid = 1'b0;
   logic [31:0] resp_instr = '0;
   logic        redir = 1'b0;
   logic [63:0] redir_pc = '0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [63:0] o_pc;
   logic [31:0] o_instr;
   logic [63:0] o_pre_pc;
   logic [2:0]  o_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_queue dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (req_valid),
      .imem_req_ready  (req_ready),
      .imem_req_addr   (req_addr),
      .imem_resp_valid (resp_valid),
      .imem_resp_instr (resp_instr),
      .redirect_valid  (redir),
      .redirect_pc     (redir_pc),
      .fetch_o_valid   (o_valid),
      .fetch_i_ready   (i_ready),
      .fetch_o_pc      (o_pc),
      .fetch_o_instr   (o_instr),
      .fetch_o_pre_pc  (o_pre_pc),
      .fetch_o_count   (o_count)
   );

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [31:0] instr;
      logic        rd;
      logic [63:0] rpc;
      logic        ird;
      logic        e_rv;
      logic [63:0] e_addr;
      logic        e_ov;
      logic [63:0] e_pc;
      logic [31:0] e_instr;
      int          e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(
      logic rdy, logic rv, logic [31:0] instr, logic rd,
      logic [63:0] rpc, logic ird, logic e_rv, logic [63:0] e_addr,
      logic e_ov, logic [63:0] e_pc, logic [31:0] e_instr, int e_cnt);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.instr = instr; v.rd = rd;
      v.rpc = rpc; v.ird = ird; v.e_rv = e_rv; v.e_addr = e_addr;
      v.e_ov = e_ov; v.e_pc = e_pc; v.e_instr = e_instr;
      v.e_cnt = e_cnt;
      vecs.push_back(v);
   endfunction

   task automatic chk(string name, int idx,
                      logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h",
                  name, idx, act, exp);
      end
   endtask

   initial begin
      // rdy rv instr redir rpc ird | req addr ov pc instr cnt
      add(1,0,0,0,0,1,          1,B,      0,0,0,0);
      add(1,1,32'hA0,0,0,1,     0,0,      0,0,0,0);
      add(1,0,0,0,0,1,          1,B+4,    1,B,32'hA0,1);
      add(1,1,32'hA1,0,0,1,     0,0,      0,0,0,0);
      add(1,0,0,0,0,1,          1,B+8,    1,B+4,32'hA1,1);
      add(1,1,32'hA2,0,0,1,     0,0,      0,0,0,0);
      add(1,0,0,0,0,0,          1,B+12,   1,B+8,32'hA2,1);
      add(1,1,32'hA3,0,0,0,     0,0,      1,B+8,32'hA2,1);
      add(1,0,0,0,0,0,          1,B+16,   1,B+8,32'hA2,2);
      add(1,1,32'hA4,0,0,0,     0,0,      1,B+8,32'hA2,2);
      add(1,0,0,0,0,0,          1,B+20,   1,B+8,32'hA2,3);
      add(1,1,32'hA5,0,0,0,     0,0,      1,B+8,32'hA2,3);
      add(1,0,0,0,0,0,          0,0,      1,B+8,32'hA2,4);
      add(1,0,0,0,0,1,          0,0,      1,B+8,32'hA2,4);
      add(1,0,0,0,0,0,          1,B+24,   1,B+12,32'hA3,3);
      add(1,0,0,1,B+256,0,      0,0,      1,B+12,32'hA3,3);
      add(1,1,32'hDEAD,0,0,0,   0,0,      0,0,0,0);
      add(1,0,0,0,0,1,          1,B+256,  0,0,0,0);
      add(1,1,32'hB0,0,0,1,     0,0,      0,0,0,0);
      add(1,0,0,0,0,0,          1,B+260,  1,B+256,32'hB0,1);
      add(1,1,32'hB1,1,B+512,1, 0,0,      1,B+256,32'hB0,1);
      add(1,0,0,0,0,1,          1,B+512,  0,0,0,0);
      add(1,1,32'hC0,0,0,1,     0,0,      0,0,0,0);
      add(1,0,0,1,WR,1,         0,0,      1,B+512,32'hC0,1);
      add(1,0,0,0,0,1,          1,WR,     0,0,0,0);
      add(1,1,32'hD0,0,0,1,     0,0,      0,0,0,0);
      add(0,0,0,0,0,0,          1,0,      1,WR,32'hD0,1);
      add(0,0,0,0,0,0,          1,0,      1,WR,32'hD0,1);
      add(0,0,0,0,0,0,          1,0,      1,WR,32'hD0,1);
      add(1,0,0,0,0,0,          1,0,      1,WR,32'hD0,1);
      add(1,0,0,0,0,0,          0,0,      1,WR,32'hD0,1);
      add(1,1,32'hE0,0,0,0,     0,0,      1,WR,32'hD0,1);
      add(1,0,0,0,0,1,          1,4,      1,WR,32'hD0,2);
      add(1,0,0,0,0,1,          0,0,      1,0,32'hE0,1);
      add(1,1,32'hE1,0,0,1,     0,0,      0,0,0,0);
      add(0,0,0,0,0,0,          1,8,      1,4,32'hE1,1);
      add(0,0,0,1,B+768,0,      0,0,      1,4,32'hE1,1);
      add(0,0,0,1,B+1024,0,     0,0,      0,0,0,0);
      add(0,0,0,0,0,0,          1,B+1024, 0,0,0,0);

      #12;
      chk("rst_req_valid", -1, 64'(req_valid), 64'd0);
      chk("rst_o_valid",   -1, 64'(o_valid),   64'd0);
      chk("rst_count",     -1, 64'(o_count),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         req_ready  = vecs[i].rdy;
         resp_valid = vecs[i].rv;
         resp_instr = vecs[i].instr;
         redir      = vecs[i].rd;
         redir_pc   = vecs[i].rpc;
         i_ready    = vecs[i].ird;
         #1;
         chk("req_valid", i, 64'(req_valid), 64'(vecs[i].e_rv));
         if (vecs[i].e_rv)
            chk("req_addr", i, req_addr, vecs[i].e_addr);
         chk("o_valid", i, 64'(o_valid), 64'(vecs[i].e_ov));
         chk("count", i, 64'(o_count), 64'(vecs[i].e_cnt));
         if (vecs[i].e_ov) begin
            chk("o_pc", i, o_pc, vecs[i].e_pc);
            chk("o_instr", i, 64'(o_instr), 64'(vecs[i].e_instr));
            chk("o_pre_pc", i, o_pre_pc, vecs[i].e_pc + 64'd4);
         end
      end

      // Reset asserted while a request is outstanding
      @(negedge clk);
      req_ready = 1'b1; resp_valid = 1'b0; redir = 1'b0; i_ready = 1'b0;
      #1;
      chk("mid_req_valid", 100, 64'(req_valid), 64'd1);
      @(negedge clk);
      req_ready = 1'b0;
      #1;
      chk("mid_busy", 101, 64'(req_valid), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req_valid", 102, 64'(req_valid), 64'd0);
      chk("mid_rst_o_valid",   102, 64'(o_valid),   64'd0);
      chk("mid_rst_count",     102, 64'(o_count),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_req_valid", 103, 64'(req_valid), 64'd1);
      chk("post_rst_addr",      103, req_addr, B);
      chk("post_rst_count",     103, 64'(o_count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
